inference_ctrl: RTL

INFERENCE_CTRL -- requirements
Module: inference_ctrl

---
 rtl/inference_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/inference_ctrl.sv
// rtl/inference_ctrl.sv - frame streaming and result capture controller for the binarised-image CNN
module inference_ctrl #(
  parameter int FRAME_BITS = 784,
  parameter int TIMEOUT    = 4095
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pix_in,
  input  logic       pix_valid,
  output logic       pix_ready,
  output logic       stream_data,
  output logic       stream_en,
  output logic       pipe_flush,
  input  logic       valid_out_fc,
  input  logic [3:0] fc_class,
  output logic [3:0] prediction,
  output logic       valid_out,
  output logic       busy,
  output logic       timeout_err
);

  localparam int               CNT_W      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(FRAME_BITS - 1);
  // The timer counts completed WAIT cycles; the one holding TIMEOUT-1 is the
  // last cycle a result may still arrive, so the flag lands exactly TIMEOUT
  // cycles after WAIT entry.
  localparam logic [11:0]      TIMER_LAST = 12'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, FLUSH, STREAM, WAIT} state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] pix_cnt;
  logic [11:0]      timer;
  logic             accept;
  logic             last_beat;
  logic             timer_hit;

  assign accept    = pix_valid && pix_ready;
  assign last_beat = (pix_cnt == LAST_BEAT);
  assign timer_hit = (timer == TIMER_LAST);

  // State register; reset drops straight to IDLE so all decoded outputs clear at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and state-decoded outputs; a result beats a simultaneous timeout.
  always_comb begin
    state_nx   = state;
    pix_ready  = 1'b0;
    pipe_flush = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = FLUSH;
      end
      FLUSH: begin
        pipe_flush = 1'b1;
        state_nx   = STREAM;
      end
      STREAM: begin
        pix_ready = 1'b1;
        if (pix_valid && last_beat) state_nx = WAIT;
      end
      WAIT: begin
        if (valid_out_fc || timer_hit) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: pixel forwarding, beat counter, result timer and result/flag capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt     <= '0;
      timer       <= '0;
      stream_data <= 1'b0;
      stream_en   <= 1'b0;
      prediction  <= 4'd0;
      valid_out   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      stream_en <= accept;
      valid_out <= 1'b0;
      if (accept) stream_data <= pix_in;
      case (state)
        IDLE: begin
          if (start) timeout_err <= 1'b0;
        end
        FLUSH: begin
          pix_cnt <= '0;
          timer   <= '0;
        end
        STREAM: begin
          if (accept) pix_cnt <= last_beat ? '0 : pix_cnt + 1'b1;
        end
        WAIT: begin
          if (valid_out_fc) begin
            prediction <= fc_class;
            valid_out  <= 1'b1;
          end else if (timer_hit) begin
            timeout_err <= 1'b1;
          end else begin
            timer <= timer + 12'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
